// File: rtl/button_io_responder_pkg.sv
// rtl/button_io_responder_pkg.sv - shared types, register map and decode for the button responder
package button_io_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int BUTTON_NUM = 3;
  localparam int COUNT_W    = 8;

  typedef logic [DATA_W-1:0]  data_path_t;
  typedef logic [ADDR_W-1:0]  data_addr_path_t;
  typedef logic [COUNT_W-1:0] press_count_t;

  localparam data_addr_path_t BTN_STATE_ADDR = 32'h0000_FF20;
  localparam data_addr_path_t BTN_EVENT_ADDR = 32'h0000_FF24;
  localparam data_addr_path_t BTN_COUNT_ADDR = 32'h0000_FF28;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_STATE,
    REG_EVENT,
    REG_COUNT
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input data_addr_path_t addr);
    case (addr)
      BTN_STATE_ADDR: return REG_STATE;
      BTN_EVENT_ADDR: return REG_EVENT;
      BTN_COUNT_ADDR: return REG_COUNT;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_io_responder_if.sv
// rtl/button_io_responder_if.sv - single-cycle CPU data-bus port of the button responder
interface button_io_responder_if;
  import button_io_responder_pkg::*;

  data_addr_path_t data_addr;
  data_path_t      data_from_cpu;
  logic            data_we;
  logic            hit;
  data_path_t      data_to_cpu;

  modport master (
    output data_addr,
    output data_from_cpu,
    output data_we,
    input  hit,
    input  data_to_cpu
  );

  modport slave (
    input  data_addr,
    input  data_from_cpu,
    input  data_we,
    output hit,
    output data_to_cpu
  );

endinterface

// File: rtl/button_io_responder_debouncer.sv
// rtl/button_io_responder_debouncer.sv - one button: 2-flop synchronizer, debounce counter, accepted level
// o_rise is combinational and marks the edge at which a 0->1 level change is accepted.
module button_io_responder_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_done;

  assign w_differ = r_sync[1] ^ r_level;
  assign w_done   = w_differ && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // The counter only survives a run of consecutive differing samples.
      if (w_done) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_done & ~r_level;

endmodule

// File: rtl/button_io_responder.sv
// rtl/button_io_responder.sv - debounced buttons exposed as state, sticky W1C events and press counters
// Reads are purely combinational; writes land on the clock edge where data_we qualifies a hit.
module button_io_responder
  import button_io_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [BUTTON_NUM-1:0] i_btn_in,
  button_io_responder_if.slave  bus
);

  logic [BUTTON_NUM-1:0] w_level;
  logic [BUTTON_NUM-1:0] w_rise;
  logic [BUTTON_NUM-1:0] r_event;
  press_count_t          r_count [BUTTON_NUM];
  reg_sel_e              w_sel;
  logic                  w_wr_event;
  logic                  w_wr_count;
  data_path_t            w_rdata;
  logic                  w_unused;

  for (genvar g = 0; g < BUTTON_NUM; g++) begin : g_btn
    button_io_responder_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_sel      = decode_addr(bus.data_addr);
  assign w_wr_event = bus.data_we && (w_sel == REG_EVENT);
  assign w_wr_count = bus.data_we && (w_sel == REG_COUNT);
  assign w_unused   = ^bus.data_from_cpu[DATA_W-1:BUTTON_NUM];

  // A same-edge acceptance beats a software clear, both for events and counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_event <= '0;
      for (int i = 0; i < BUTTON_NUM; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUTTON_NUM; i++) begin
        r_event[i] <= w_rise[i] | (r_event[i] & ~(w_wr_event & bus.data_from_cpu[i]));
        if (w_rise[i]) begin
          r_count[i] <= w_wr_count ? press_count_t'(1) : r_count[i] + press_count_t'(1);
        end else if (w_wr_count) begin
          r_count[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_STATE: w_rdata[BUTTON_NUM-1:0] = w_level;
      REG_EVENT: w_rdata[BUTTON_NUM-1:0] = r_event;
      REG_COUNT: begin
        for (int i = 0; i < BUTTON_NUM; i++) begin
          w_rdata[i*COUNT_W +: COUNT_W] = r_count[i];
        end
      end
      default: w_rdata = '0;
    endcase
  end

  assign bus.hit         = (w_sel != REG_NONE);
  assign bus.data_to_cpu = w_rdata;

endmodule

// File: tb/tb_button_io_responder.sv
// tb/tb_button_io_responder.sv - directed vector bench for button_io_responder
// Vector tables cover register access; hand sequences cover debounce timing and edge collisions.
module tb_button_io_responder;
  import button_io_responder_pkg::*;

  localparam int DB  = 16;
  localparam int LAT = 2 + DB;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  int         n_checks;
  int         n_fail;
  int         vec_id;
  int         lat;
  vec_t       vecs[$];

  button_io_responder_if bus ();

  button_io_responder #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_in (btn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_hit, input logic [31:0] exp_data);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_hit = exp_hit; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  // Each vector: drive, check combinational read and hit, then clock (write lands on that edge).
  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      bus.data_addr     = vecs[i].addr;
      bus.data_from_cpu = vecs[i].wdata;
      bus.data_we       = vecs[i].we;
      #1;
      check($sformatf("vec%0d data", vec_id), bus.data_to_cpu, vecs[i].exp_data);
      check($sformatf("vec%0d hit", vec_id), {31'b0, bus.hit}, {31'b0, vecs[i].exp_hit});
      vec_id++;
      @(posedge clk);
      #1;
      bus.data_we = 1'b0;
    end
    vecs.delete();
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.data_we   = 1'b0;
    bus.data_addr = addr;
    #1;
    check(name, bus.data_to_cpu, exp);
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    btn = mask;
    tick(hold);
    btn = 3'b000;
    tick(gap);
  endtask

  // Edges until STATE[bitn] is first seen high, bounded at 40.
  task automatic measure(input int bitn, output int l);
    l = -1;
    bus.data_we   = 1'b0;
    bus.data_addr = BTN_STATE_ADDR;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (l < 0 && bus.data_to_cpu[bitn]) l = k;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vec_id   = 0;
    rst      = 1'b0;
    btn      = 3'b000;
    bus.data_addr     = '0;
    bus.data_from_cpu = '0;
    bus.data_we       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state, unmapped access, ignored writes
    add(0, BTN_STATE_ADDR, 0, 1, 32'h0);
    add(0, BTN_EVENT_ADDR, 0, 1, 32'h0);
    add(0, BTN_COUNT_ADDR, 0, 1, 32'h0);
    add(0, 32'h0000_0100,  0, 0, 32'h0);
    add(1, BTN_STATE_ADDR, 32'hFFFF_FFFF, 1, 32'h0);
    add(1, 32'h0000_FF2C,  32'hFFFF_FFFF, 0, 32'h0);
    add(0, BTN_STATE_ADDR, 0, 1, 32'h0);
    run_vecs();

    // BTNU held 40 cycles: acceptance latency and side effects
    btn = 3'b010;
    measure(1, lat);
    check("btnu latency", 32'(lat), 32'(LAT));
    btn = 3'b000;
    tick(20);
    add(0, BTN_STATE_ADDR, 0, 1, 32'h0);
    add(0, BTN_EVENT_ADDR, 0, 1, 32'h2);
    add(0, BTN_COUNT_ADDR, 0, 1, 32'h0000_0100);
    add(1, BTN_EVENT_ADDR, 32'h7, 1, 32'h2);
    add(1, BTN_COUNT_ADDR, 32'h0, 1, 32'h0000_0100);
    add(0, BTN_EVENT_ADDR, 0, 1, 32'h0);
    add(0, BTN_COUNT_ADDR, 0, 1, 32'h0);
    run_vecs();

    // BTNC bouncing at a 5-cycle period is never accepted
    for (int p = 0; p < 20; p++) press(3'b001, 3, 2);
    tick(20);
    rd_check("bounce state", BTN_STATE_ADDR, 32'h0);
    rd_check("bounce event", BTN_EVENT_ADDR, 32'h0);
    rd_check("bounce count", BTN_COUNT_ADDR, 32'h0);

    // Pulse of DB-1 cycles rejected, DB cycles accepted
    press(3'b001, DB - 1, 25);
    rd_check("short pulse event", BTN_EVENT_ADDR, 32'h0);
    rd_check("short pulse count", BTN_COUNT_ADDR, 32'h0);
    press(3'b001, DB, 25);
    rd_check("exact pulse event", BTN_EVENT_ADDR, 32'h1);
    rd_check("exact pulse count", BTN_COUNT_ADDR, 32'h1);

    // All buttons, then W1C of 0x5
    press(3'b111, 20, 20);
    add(0, BTN_EVENT_ADDR, 0, 1, 32'h7);
    add(0, BTN_COUNT_ADDR, 0, 1, 32'h0001_0102);
    add(1, BTN_EVENT_ADDR, 32'h5, 1, 32'h7);
    add(0, BTN_EVENT_ADDR, 0, 1, 32'h2);
    run_vecs();

    // W1C of bit0 on the same edge BTNC is accepted: set wins
    btn = 3'b001;
    tick(LAT - 1);
    bus.data_addr     = BTN_EVENT_ADDR;
    bus.data_from_cpu = 32'h1;
    bus.data_we       = 1'b1;
    @(posedge clk);
    #1;
    bus.data_we = 1'b0;
    rd_check("w1c vs set event", BTN_EVENT_ADDR, 32'h3);
    rd_check("w1c vs set state", BTN_STATE_ADDR, 32'h1);
    btn = 3'b000;
    tick(20);
    rd_check("count after c", BTN_COUNT_ADDR, 32'h0001_0103);

    // Counter clear on the same edge BTND is accepted: result is 1
    btn = 3'b100;
    tick(LAT - 1);
    bus.data_addr     = BTN_COUNT_ADDR;
    bus.data_from_cpu = 32'h0;
    bus.data_we       = 1'b1;
    @(posedge clk);
    #1;
    bus.data_we = 1'b0;
    rd_check("clear vs inc count", BTN_COUNT_ADDR, 32'h0001_0000);
    btn = 3'b000;
    tick(20);
    rd_check("event after d", BTN_EVENT_ADDR, 32'h7);

    // 257 BTND presses: wrap at 256
    add(1, BTN_COUNT_ADDR, 32'h0, 1, 32'h0001_0000);
    run_vecs();
    for (int p = 0; p < 255; p++) press(3'b100, 20, 20);
    rd_check("count 255", BTN_COUNT_ADDR, 32'h00FF_0000);
    press(3'b100, 20, 20);
    rd_check("count wrap", BTN_COUNT_ADDR, 32'h0000_0000);
    press(3'b100, 20, 20);
    rd_check("count 257", BTN_COUNT_ADDR, 32'h0001_0000);

    // One-cycle reset mid-debounce with BTNC held
    btn = 3'b001;
    tick(8);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd_check("rst state", BTN_STATE_ADDR, 32'h0);
    rd_check("rst event", BTN_EVENT_ADDR, 32'h0);
    rd_check("rst count", BTN_COUNT_ADDR, 32'h0);
    measure(0, lat);
    check("post-reset latency", 32'(lat), 32'(LAT));
    rd_check("post-reset count", BTN_COUNT_ADDR, 32'h1);
    rd_check("post-reset event", BTN_EVENT_ADDR, 32'h1);
    btn = 3'b000;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_io_responder.md
BUTTON_IO_RESPONDER -- requirements
Module: ButtonIOResponder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required before a button level change is accepted.
REQ-002 clk  input  1  core clock, sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 btnIn  input  3  raw asynchronous buttons; bit0 BTNC, bit1 BTNU, bit2 BTND.
REQ-005 dataAddr  input  DataAddrPath  CPU data-bus address.
REQ-006 dataFromCPU  input  DataPath  CPU write data.
REQ-007 dataWE  input  1  CPU write strobe, qualified with dataAddr in the same cycle.
REQ-008 hit  output  1  high combinationally when dataAddr matches one of this block's registers.
REQ-009 dataToCPU  output  DataPath  combinational read data; 0 when hit is low.

Function
REQ-010 Each btnIn bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-011 Per button, a debounce counter SHALL increment while the synchronized level differs from the accepted level, SHALL clear whenever they match, and on reaching DEBOUNCE_CYCLES-1 the accepted level SHALL flip and the counter clear in the same edge.
REQ-012 Total latency, raw press to accepted level change: 2 + DEBOUNCE_CYCLES cycles for a clean input.
REQ-013 An accepted 0->1 transition SHALL set that button's sticky event bit and increment its 8-bit press counter, wrapping 255->0.
REQ-014 Register BTN_STATE_ADDR (read-only): bits[2:0] = accepted levels, upper bits 0.
REQ-015 Register BTN_EVENT_ADDR: bits[2:0] = sticky event bits; a write clears every event bit whose dataFromCPU bit is 1 (write-1-to-clear).
REQ-016 Register BTN_COUNT_ADDR: bits[7:0]/[15:8]/[23:16] = C/U/D press counters, [31:24] 0; any write clears all three counters.
REQ-017 Reads SHALL be combinational in the same cycle as dataAddr, with no side effects (single-cycle CPU timing).
REQ-018 Writes take effect at the rising edge where dataWE=1 and the address hits; writes to BTN_STATE_ADDR or non-hit addresses SHALL be ignored.
REQ-019 If an event set and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-020 If a counter increment and a counter-clear write coincide, the result SHALL be 1.
REQ-021 A raw pulse shorter than DEBOUNCE_CYCLES SHALL change no register.

Reset
REQ-022 With rst=0 at a rising edge: synchronizers, accepted levels, debounce counters, event bits and press counters SHALL become 0.
REQ-023 Reset SHALL override any simultaneous write or debounce completion; a button held through reset deassertion is registered as a fresh press after 2 + DEBOUNCE_CYCLES cycles.

Structure
REQ-024 BTN_STATE_ADDR, BTN_EVENT_ADDR, BTN_COUNT_ADDR, BUTTON_NUM (=3) and the press-counter typedef SHALL live in the shared Types package.
REQ-025 One sub-module, ButtonDebouncer (synchronizer + counter + accepted level + rising-edge pulse), SHALL be instantiated BUTTON_NUM times.

Verification
REQ-026 Reset, then read all three registers -> 0, 0, 0; hit=1 for each, and dataToCPU=0 at an unmapped address with hit=0.
REQ-027 Hold BTNU=1 for 40 cycles (DEBOUNCE_CYCLES=16) -> BTN_STATE bit1 rises exactly 18 cycles after the input rises; EVENT=0x2; COUNT=0x00000100.
REQ-028 Toggle BTNC at a 5-cycle period for 100 cycles -> STATE, EVENT and COUNT stay 0.
REQ-029 EVENT=0x7, write 0x5 to BTN_EVENT_ADDR -> EVENT=0x2; a write of 0x1 in the same cycle as a new BTNC acceptance -> bit0 remains 1.
REQ-030 Perform 256 clean BTND presses -> COUNT[23:16] wraps to 0x00; a 257th press -> 0x01.
REQ-031 Assert rst=0 for 1 cycle mid-debounce with BTNC held -> all registers 0, then STATE bit0=1 and COUNT=0x1 after 18 cycles.
